gate_test_sequencer: RTL

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

---
 rtl/gate_test_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/gate_test_sequencer.sv
// Drives the four input vectors of a two-input gate, holds each for SETTLE cycles,
// samples Y against TRUTH and reports a per-vector fail mask, error count and pass flag.
module gate_test_sequencer #(
  parameter int unsigned SETTLE = 4,
  parameter logic [3:0]  TRUTH  = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned ERR_W = 3;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(4);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [3:0]         fail_q, fail_d;
  logic               pass_q, pass_d;
  logic               a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d;

  // State, datapath and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and result bookkeeping
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (Y != TRUTH[idx_q]) begin
          fail_d[idx_q] = 1'b1;
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          pass_d  = (fail_d == 4'b0000);
        end else begin
          state_d = S_APPLY;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they register alongside it
  always_comb begin
    a_d    = 1'b0;
    b_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == S_APPLY || state_d == S_SAMPLE) begin
      a_d    = idx_d[1];
      b_d    = idx_d[0];
      busy_d = 1'b1;
    end
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule
